uart_tx_sched: RTL and testbench

- Two-requester UART transmit controller: round-robin arbitration between two byte sources, one shared serial line.
- Contains its own bit-period counter and the frame sequencer.
- Sits between the on-chip producers (command echo, status reporter) and the tx pin.
- Bit timing comes from the system clock divided by CLKS_PER_BIT.

---
 rtl/uart_tx_sched_if.sv | 19 +
 rtl/uart_tx_sched.sv | 112 +++++++++++
 tb/tb_uart_tx_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester handshake bundle for the two-source UART transmitter
interface uart_tx_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin two-requester UART transmitter with bit timer and frame sequencer
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 88,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.slave req,
    output logic           tx,
    output logic           busy,
    output logic           grant_id,
    output logic           frame_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic        LAST_STOP = (STOP_BITS == 2);

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic        stop_cnt;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic        last_grant;
    logic        sel;

    // On a tie the requester that did not win last time is selected
    always_comb begin
        sel = req.req1_valid;
        if (req.req0_valid && req.req1_valid) begin
            sel = ~last_grant;
        end
    end

    assign req.req0_ready = (state == IDLE) && req.req0_valid && !sel;
    assign req.req1_ready = (state == IDLE) && req.req1_valid && sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            last_grant <= 1'b1;
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                if (req.req0_ready || req.req1_ready) begin
                    shift_reg  <= sel ? req.req1_data : req.req0_data;
                    parity_bit <= sel ? ^req.req1_data : ^req.req0_data;
                    grant_id   <= sel;
                    last_grant <= sel;
                    busy       <= 1'b1;
                    state      <= START;
                    clk_cnt    <= '0;
                    tx         <= 1'b0;
                end
            end else if (clk_cnt != LAST_CNT) begin
                clk_cnt <= clk_cnt + 16'd1;
            end else begin
                // tx is loaded on the edge that enters each bit so every bit spans a full period
                clk_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state    <= STOP;
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched against a frame-level model
module tb_uart_tx_sched;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_sched_if ia ();
    uart_tx_sched_if ib ();

    logic tx_a, busy_a, gid_a, fd_a;
    logic tx_b, busy_b, gid_b, fd_b;

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .req(ia),
        .tx(tx_a), .busy(busy_a), .grant_id(gid_a), .frame_done(fd_a)
    );

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .req(ib),
        .tx(tx_b), .busy(busy_b), .grant_id(gid_b), .frame_done(fd_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_last [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit b, input bit v0, input bit v1,
                         input logic [7:0] d0, input logic [7:0] d1);
        if (b) begin
            ib.req0_valid = v0; ib.req1_valid = v1; ib.req0_data = d0; ib.req1_data = d1;
        end else begin
            ia.req0_valid = v0; ia.req1_valid = v1; ia.req0_data = d0; ia.req1_data = d1;
        end
    endtask

    // {tx, busy, frame_done, req0_ready, req1_ready}
    function automatic logic [4:0] obs(input bit b);
        if (b) return {tx_b, busy_b, fd_b, ib.req0_ready, ib.req1_ready};
        return {tx_a, busy_a, fd_a, ia.req0_ready, ia.req1_ready};
    endfunction

    function automatic logic gid(input bit b);
        return b ? gid_b : gid_a;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last[0] = 1'b1;
        model_last[1] = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle after the frame.
    task automatic frame(input bit b, input bit v0, input bit v1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input bit disturb, output int acc);
        bit         w;
        bit         ov;
        bit         wave [$];
        logic [7:0] d;
        logic [7:0] cd0;
        logic [7:0] cd1;
        logic [4:0] o;
        int         n;
        w  = (v0 && v1) ? !model_last[b] : v1;
        d  = w ? d1 : d0;
        ov = 1'b0;
        wave = {};
        wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) wave.push_back(d[i]);
        if (b) wave.push_back(^d);
        repeat (b ? 2 : 1) wave.push_back(1'b1);
        n = wave.size() * CPB;
        cd0 = d0;
        cd1 = d1;
        drive(b, v0, v1, cd0, cd1);
        #1;
        o = obs(b);
        check("accept_ready", {30'd0, o[1:0]}, w ? 32'd1 : 32'd2);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        model_last[b] = w;
        if (w) begin v1 = 1'b0; cd1 = ~d1; end
        else begin v0 = 1'b0; cd0 = ~d0; end
        drive(b, v0, v1, cd0, cd1);
        #1;
        check("grant_id", {31'd0, gid(b)}, {31'd0, w});
        for (int k = 0; k < n; k++) begin
            o = obs(b);
            check("frame_bit", {27'd0, o}, {27'd0, wave[k / CPB], 4'b1000});
            if (disturb && k == 5 && !(w ? v0 : v1)) begin
                ov = 1'b1;
                if (w) v0 = 1'b1; else v1 = 1'b1;
                drive(b, v0, v1, cd0, cd1);
            end
            if (disturb && k == 6 && ov) begin
                if (w) v0 = 1'b0; else v1 = 1'b0;
                drive(b, v0, v1, cd0, cd1);
            end
            @(negedge clk);
            #1;
        end
        drive(b, 0, 0, cd0, cd1);
        #1;
        o = obs(b);
        check("frame_end", {27'd0, o}, {27'd0, 5'b10100});
    endtask

    int         acc;
    int         prev;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [4:0] o;
    bit         rv0;
    bit         rv1;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        do_reset();

        for (int i = 0; i < 50; i++) begin
            #1;
            check("idle_a", {27'd0, obs(0)}, {27'd0, 5'b10000});
            check("idle_b", {27'd0, obs(1)}, {27'd0, 5'b10000});
            check("idle_gid", {30'd0, gid_a, gid_b}, 32'd0);
            @(negedge clk);
        end

        frame(0, 1, 0, 8'hA5, 8'h00, 0, acc);
        @(negedge clk);
        #1;
        check("after_single", {27'd0, obs(0)}, {27'd0, 5'b10000});
        @(negedge clk);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            prev = acc;
            frame(0, 1, 1, 8'h11, 8'h22, 0, acc);
            check("contention_grant", {31'd0, gid_a}, i[31:0] & 32'd1);
            if (i > 0) check("b2b_spacing", acc - prev, 32'd41);
        end
        @(negedge clk);

        frame(1, 0, 1, 8'h00, 8'h07, 0, acc);
        @(negedge clk);

        drive(0, 1, 0, 8'hFF, 8'h00);
        #1;
        check("rst_frame_ready", {27'd0, obs(0)}, {27'd0, 5'b10010});
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 8'hFF, 8'h00);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last[0] = 1'b1;
        model_last[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("post_reset", {27'd0, obs(0)}, {27'd0, 5'b10000});
            @(negedge clk);
        end
        frame(0, 1, 1, 8'h3C, 8'hC3, 0, acc);
        check("post_reset_grant", {31'd0, gid_a}, 32'd0);
        @(negedge clk);

        frame(0, 1, 0, 8'h5A, 8'h00, 1, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("no_extra_frame", {27'd0, obs(0)}, {27'd0, 5'b10000});
        end
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            frame(i[0], rv0, rv1, r0, r1, 1'($urandom_range(0, 1)), acc);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
